// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default constants, fetch state encoding
// and the word-alignment helper applied to every PC load.
package pc_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;   // ADDI x0,x0,0

    typedef enum logic {
        S_REQ   = 1'b0,
        S_DRAIN = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_ifid_reg.sv
// Pipeline register between IF and ID: load captures a fetched instruction,
// bubble replaces the instruction with a NOP while keeping the PC fields.
module pc_fetch_unit_ifid_reg #(
    parameter logic [31:0] NOP_INSTR = pc_fetch_unit_pkg::NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instr,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= 32'h0;
            pc4   <= 32'h0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= pc_in;
            pc4   <= pc_in + 32'd4;
            instr <= instr_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, runs the instruction-memory handshake and feeds IF/ID,
// honouring redirects from the branch/jump unit and draining stale accesses.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_REQ   | fetching at PC; redirects and flushes act directly
// S_DRAIN | stale access still busy; pending target loads once it ends
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PCMUX,
    input  logic [31:0] BRANCH_JUMP_TARGET,
    input  logic        REG_FLUSH,
    input  logic        STALL,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_INSTR,
    output logic        IFID_VALID,
    output logic        FETCH_BUSY
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pending;
    logic         read_en;
    logic [31:0]  target;
    logic         ifid_load;
    logic         ifid_bubble;

    assign target = word_align(BRANCH_JUMP_TARGET);

    // PC does not move while draining, so the address bus keeps the stale request.
    assign IMEM_READ  = read_en;
    assign IMEM_ADDR  = pc;
    assign FETCH_BUSY = (state == S_DRAIN) | (read_en & IMEM_BUSYWAIT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            pending <= 32'h0;
            read_en <= 1'b0;
        end else begin
            read_en <= 1'b1;
            case (state)
                S_REQ: begin
                    if (!read_en) begin
                        if (PCMUX) pc <= target;
                    end else if (PCMUX && !IMEM_BUSYWAIT) begin
                        pc <= target;
                    end else if (PCMUX) begin
                        pending <= target;
                        state   <= S_DRAIN;
                    end else if (REG_FLUSH) begin
                        if (!IMEM_BUSYWAIT) pc <= pc + 32'd4;
                    end else if (!STALL && !IMEM_BUSYWAIT) begin
                        pc <= pc + 32'd4;
                    end
                end
                S_DRAIN: begin
                    if (!IMEM_BUSYWAIT) begin
                        pc    <= PCMUX ? target : pending;
                        state <= S_REQ;
                    end else if (PCMUX) begin
                        pending <= target;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (state == S_DRAIN) begin
            ifid_bubble = 1'b1;
        end else if (!read_en) begin
            ifid_bubble = PCMUX | REG_FLUSH;
        end else if (PCMUX || REG_FLUSH) begin
            ifid_bubble = 1'b1;
        end else if (STALL) begin
            ifid_bubble = 1'b0;
        end else if (IMEM_BUSYWAIT) begin
            ifid_bubble = 1'b1;
        end else begin
            ifid_load = 1'b1;
        end
    end

    pc_fetch_unit_ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk      (CLK),
        .reset    (RESET),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .pc_in    (pc),
        .instr_in (IMEM_READDATA),
        .pc       (IFID_PC),
        .pc4      (IFID_PC4),
        .instr    (IFID_INSTR),
        .valid    (IFID_VALID)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed redirect/stall/drain/wrap scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        RESET;
    logic        PCMUX;
    logic [31:0] BRANCH_JUMP_TARGET;
    logic        REG_FLUSH;
    logic        STALL;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_PC4;
    logic [31:0] IFID_INSTR;
    logic        IFID_VALID;
    logic        FETCH_BUSY;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_pc, m_pend, m_ifid_pc, m_ifid_pc4, m_ifid_instr;
    logic        m_rd, m_drain, m_ifid_valid;

    pc_fetch_unit dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .PCMUX              (PCMUX),
        .BRANCH_JUMP_TARGET (BRANCH_JUMP_TARGET),
        .REG_FLUSH          (REG_FLUSH),
        .STALL              (STALL),
        .IMEM_READ          (IMEM_READ),
        .IMEM_ADDR          (IMEM_ADDR),
        .IMEM_READDATA      (IMEM_READDATA),
        .IMEM_BUSYWAIT      (IMEM_BUSYWAIT),
        .IFID_PC            (IFID_PC),
        .IFID_PC4           (IFID_PC4),
        .IFID_INSTR         (IFID_INSTR),
        .IFID_VALID         (IFID_VALID),
        .FETCH_BUSY         (FETCH_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1ms;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_bubble();
        m_ifid_instr = NOP;
        m_ifid_valid = 1'b0;
    endtask

    // One rising edge of the reference model, written directly from the fetch rules.
    task automatic model_step(input logic rst, input logic pcmux, input logic [31:0] tgt,
                              input logic flush, input logic stall, input logic busy);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (rst) begin
            m_pc = 32'h0; m_pend = 32'h0; m_rd = 1'b0; m_drain = 1'b0;
            m_ifid_pc = 32'h0; m_ifid_pc4 = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
        end else if (!m_rd) begin
            m_rd = 1'b1;
            if (pcmux) begin m_pc = t; m_bubble(); end
            else if (flush) m_bubble();
        end else if (m_drain) begin
            m_bubble();
            if (!busy) begin
                m_pc = pcmux ? t : m_pend;
                m_drain = 1'b0;
            end else if (pcmux) m_pend = t;
        end else if (pcmux) begin
            m_bubble();
            if (busy) begin m_pend = t; m_drain = 1'b1; end
            else m_pc = t;
        end else if (flush) begin
            m_bubble();
            if (!busy) m_pc = m_pc + 32'd4;
        end else if (stall) begin
            // hold everything, same address is fetched again
        end else if (busy) begin
            m_bubble();
        end else begin
            m_ifid_pc    = m_pc;
            m_ifid_pc4   = m_pc + 32'd4;
            m_ifid_instr = mem_word(m_pc);
            m_ifid_valid = 1'b1;
            m_pc         = m_pc + 32'd4;
        end
    endtask

    // Called just after a rising edge; drives one cycle, checks, and steps the model.
    task automatic drive_cycle(input logic rst, input logic pcmux, input logic [31:0] tgt,
                               input logic flush, input logic stall, input logic busy);
        RESET = rst; PCMUX = pcmux; BRANCH_JUMP_TARGET = tgt;
        REG_FLUSH = flush; STALL = stall; IMEM_BUSYWAIT = busy;
        #1 IMEM_READDATA = mem_word(IMEM_ADDR);
        #1;
        check("imem_read",  {31'h0, IMEM_READ},  {31'h0, m_rd});
        check("imem_addr",  IMEM_ADDR,           m_pc);
        check("fetch_busy", {31'h0, FETCH_BUSY}, {31'h0, m_drain | (m_rd & busy)});
        check("ifid_pc",    IFID_PC,             m_ifid_pc);
        check("ifid_pc4",   IFID_PC4,            m_ifid_pc4);
        check("ifid_instr", IFID_INSTR,          m_ifid_instr);
        check("ifid_valid", {31'h0, IFID_VALID}, {31'h0, m_ifid_valid});
        @(posedge CLK);
        model_step(rst, pcmux, tgt, flush, stall, busy);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        drive_cycle(1'b0, 1'b1, tgt, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RESET = 1'b1; PCMUX = 1'b0; BRANCH_JUMP_TARGET = 32'h0; REG_FLUSH = 1'b0;
        STALL = 1'b0; IMEM_BUSYWAIT = 1'b0; IMEM_READDATA = 32'h0;
        m_pc = 32'h0; m_pend = 32'h0; m_rd = 1'b0; m_drain = 1'b0;
        m_ifid_pc = 32'h0; m_ifid_pc4 = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
        @(posedge CLK); #1;

        // reset and first fetch
        drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rst_read",  {31'h0, IMEM_READ},  32'h0);
        check("rst_valid", {31'h0, IFID_VALID}, 32'h0);
        check("rst_instr", IFID_INSTR,          NOP);
        check("rst_pc",    IFID_PC,             32'h0);
        run(1);
        check("first_read", {31'h0, IMEM_READ}, 32'h1);
        check("first_addr", IMEM_ADDR,          32'h0);
        run(1);
        check("first_ifid_pc",    IFID_PC,             32'h0);
        check("first_ifid_instr", IFID_INSTR,          32'h0050_0093);
        check("first_ifid_valid", {31'h0, IFID_VALID}, 32'h1);
        check("first_next_addr",  IMEM_ADDR,           32'h4);

        // sequential fetch up to PC=0x10
        run(3);
        check("seq_addr",     IMEM_ADDR, 32'h10);
        check("seq_ifid_pc4", IFID_PC4,  32'h10);

        // redirect with an unaligned target
        redirect(32'h0000_0103);
        check("redir_addr",  IMEM_ADDR,           32'h100);
        check("redir_valid", {31'h0, IFID_VALID}, 32'h0);
        check("redir_instr", IFID_INSTR,          NOP);
        run(1);
        check("redir_ifid_pc", IFID_PC,             32'h100);
        check("redir_valid2",  {31'h0, IFID_VALID}, 32'h1);

        // PCMUX wins over STALL, then STALL alone holds
        redirect(32'h20);
        drive_cycle(1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0);
        check("stall_redir_addr",  IMEM_ADDR,           32'h80);
        check("stall_redir_valid", {31'h0, IFID_VALID}, 32'h0);
        run(1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            check("stall_addr",    IMEM_ADDR, 32'h84);
            check("stall_ifid_pc", IFID_PC,   32'h80);
        end

        // redirect during wait: newest pending target wins
        redirect(32'h40);
        drive_cycle(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        check("drain_busy",      {31'h0, FETCH_BUSY}, 32'h1);
        check("drain_stale_addr", IMEM_ADDR,          32'h40);
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("drain_next_addr", IMEM_ADDR,           32'h300);
        check("drain_valid",     {31'h0, IFID_VALID}, 32'h0);
        run(1);
        check("drain_ifid_pc", IFID_PC, 32'h300);

        // PC wrap
        redirect(32'hFFFF_FFFC);
        run(1);
        check("wrap_addr",     IMEM_ADDR, 32'h0);
        check("wrap_ifid_pc",  IFID_PC,   32'hFFFF_FFFC);
        check("wrap_ifid_pc4", IFID_PC4,  32'h0);

        // reset while draining
        redirect(32'h500);
        drive_cycle(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1);
        check("rst_drain_read", {31'h0, IMEM_READ},  32'h0);
        check("rst_drain_busy", {31'h0, FETCH_BUSY}, 32'h0);
        run(1);
        check("rst_drain_addr", IMEM_ADDR, 32'h0);
        run(1);
        check("rst_drain_ifid", IFID_PC, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive_cycle($urandom_range(0, 199) == 0,
                        $urandom_range(0, 5) == 0,
                        $urandom,
                        $urandom_range(0, 9) == 0,
                        $urandom_range(0, 5) == 0,
                        $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the branch/jump redirect interface: owns the PC, fetches instructions from instruction memory over a read/busywait handshake, and drives the IF/ID pipeline register.
- Takes PCMUX and BRANCH_JUMP_TARGET from the EX-stage branch/jump unit. On PCMUX it redirects the PC. On PCMUX or REG_FLUSH it squashes IF/ID to a NOP bubble.
- Discards any in-flight fetch made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (ADDI x0,x0,0) written into IF/ID on flush.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- PCMUX  input  1  redirect request from the branch/jump unit
- BRANCH_JUMP_TARGET  input  32  redirect target, valid when PCMUX=1
- REG_FLUSH  input  1  squash IF/ID contents
- STALL  input  1  hazard-unit stall: hold PC and IF/ID
- IMEM_READ  output  1  instruction memory read request
- IMEM_ADDR  output  32  fetch address
- IMEM_READDATA  input  32  instruction word, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
- IMEM_BUSYWAIT  input  1  memory not ready
- IFID_PC  output  32  PC of the instruction in IF/ID
- IFID_PC4  output  32  IFID_PC+4
- IFID_INSTR  output  32  instruction in IF/ID
- IFID_VALID  output  1  IF/ID holds a real instruction
- FETCH_BUSY  output  1  fetch stage waiting on memory (status/perf)

Behaviour:
- One clock CLK; RESET is synchronous and active-high. All state updates on the rising CLK edge.
- Reset values: PC=RESET_PC, state=S_REQ, IMEM_READ=0 during the reset cycle, IFID_PC=0, IFID_PC4=0, IFID_INSTR=NOP_INSTR, IFID_VALID=0, FETCH_BUSY=0, pending target=0.
- A reset asserted mid-fetch or mid-drain abandons the access. The first request after reset is at RESET_PC.
- States: S_REQ (issue or continue fetch), S_DRAIN (stale access outstanding).
- S_REQ outputs: IMEM_READ=1, IMEM_ADDR=PC. FETCH_BUSY=IMEM_BUSYWAIT.
- S_REQ decision order at each edge (first match wins):
  1. PCMUX=1, BUSYWAIT=0: PC<=target. IF/ID<=bubble. Stay in S_REQ.
  2. PCMUX=1, BUSYWAIT=1: pending<=target. IF/ID<=bubble. Go to S_DRAIN.
  3. REG_FLUSH=1 without PCMUX: IF/ID<=bubble. PC advances by 4 only if BUSYWAIT=0.
  4. STALL=1: PC and IF/ID hold. The fetched data is dropped and the same address is refetched.
  5. BUSYWAIT=1: PC holds. IF/ID<=bubble.
  6. Otherwise: IF/ID<={PC, PC+4, IMEM_READDATA, VALID=1}. PC<=PC+4.
- Bubble = {IFID_PC and IFID_PC4 hold their values, INSTR=NOP_INSTR, VALID=0}.
- Latency: one instruction per cycle when BUSYWAIT stays low. A redirect takes effect on the next edge; the first target instruction appears in IF/ID one edge after that.
- S_DRAIN outputs: IMEM_READ=1, IMEM_ADDR=stale PC (the request cannot be aborted). IF/ID=bubble every cycle. FETCH_BUSY=1.
  - A new PCMUX overwrites the pending target (newest wins).
  - When BUSYWAIT=0: data discarded, PC<=pending (or the concurrent PCMUX target), go to S_REQ.
  - STALL is ignored in S_DRAIN.
- Arithmetic and width rules:
  - Targets are forced word-aligned: PC[1:0]<=2'b00 on every load.
  - PC+4 wraps modulo 2^32: 0xFFFF_FFFC -> 0x0000_0000.
  - IFID_PC4 is computed from the captured PC, not the new PC.
- Simultaneous PCMUX and STALL: PCMUX wins, because the redirecting instruction is older than the stalled one.

Decomposition:
- Shared package contains: NOP_INSTR constant, the fetch state encoding (S_REQ, S_DRAIN), and the RESET_PC default.
- Sub-module ifid_reg: the IF/ID register with load, hold and bubble controls, reused for the later pipeline registers.
- PC register, FSM and pending-target register stay in pc_fetch_unit.

Test Plan:
- Reset: RESET=1 for 2 cycles, then release with BUSYWAIT=0 and READDATA=0x00500093. Edge 1: IMEM_ADDR=0x0. Next edge: IFID_PC=0x0, IFID_INSTR=0x00500093, IFID_VALID=1, PC=0x4.
- Sequential fetch, zero wait: 4 cycles give IMEM_ADDR 0x0, 0x4, 0x8, 0xC, with IFID_PC4 = IFID_PC+4 each cycle.
- Redirect, no wait: PCMUX=1 with target 0x0000_0103 while PC=0x10. Next edge: PC=0x100, IFID_VALID=0, IFID_INSTR=0x13. The edge after: IFID_PC=0x100, VALID=1.
- STALL together with PCMUX at PC=0x20 with target 0x80: PC=0x80, IF/ID bubble. STALL alone for 3 cycles: PC and IF/ID unchanged, IMEM_ADDR stays constant.
- Redirect during wait: BUSYWAIT=1 for 3 cycles at PC=0x40. PCMUX is asserted with target 0x200 in cycle 1, then again with 0x300 in cycle 2. Then BUSYWAIT=0. Required: the data from 0x40 is never valid in IF/ID, the next IMEM_ADDR is 0x300, and FETCH_BUSY=1 throughout.
- Wrap and reset mid-drain: at PC=0xFFFF_FFFC a normal fetch sets PC=0x0. Separately, RESET during S_DRAIN gives IMEM_READ=0 that cycle, and the next fetch is at RESET_PC.
